// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

  // Frame tracking states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP1  = 3'd3,
    STOP2  = 3'd4
  } rx_state_e;

  // par_type encoding
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // two_stop encoding
  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  // Smallest Prescale for which the edge counter produces a usable strobe
  localparam int unsigned MIN_PRESCALE = 32'd2;

endpackage : uart_rx_pkg

// File: rtl/uart_parity_calc.sv
// Expected parity bit for a data word; shared between the RX and TX paths.
module uart_parity_calc
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_type_i,
  output logic                  par_o
);

  // Even parity makes the total count of ones even; odd parity inverts it
  assign par_o = (par_type_i == PAR_ODD) ? ~(^data_i) : (^data_i);

endmodule : uart_parity_calc

// File: rtl/uart_rx_frame_check.sv
// UART receive frame checker: assembles data bits, checks parity and stop
// bits, and flags breaks for one frame at a time on the shared edge counter.
module uart_rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic                      sampled_bit,
  input  logic                      frame_start,
  input  logic                      par_en,
  input  logic                      par_type,
  input  logic                      two_stop,
  output logic                      busy,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      frame_done,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err,
  output logic                      brk_det
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [PRESCALE_WIDTH-1:0] MIN_PS = PRESCALE_WIDTH'(MIN_PRESCALE);

  rx_state_e               state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    valid_q, valid_d;
  logic                    par_err_q, par_err_d;
  logic                    stp_err_q, stp_err_d;
  logic                    brk_q, brk_d;
  logic                    zero_q, zero_d;      // every line bit so far was 0
  logic                    par_en_q, par_en_d;
  logic                    par_type_q, par_type_d;
  logic                    two_stop_q, two_stop_d;

  logic [PRESCALE_WIDTH-1:0] prescale_m1_s;
  logic                      prescale_ok_s;
  logic                      strobe_s;
  logic                      exp_par_s;

  assign prescale_m1_s = Prescale - PRESCALE_WIDTH'(1);
  assign prescale_ok_s = (Prescale >= MIN_PS);
  assign strobe_s      = busy_q && (edge_cnt == prescale_m1_s);

  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data_i     (data_q),
    .par_type_i (par_type_q),
    .par_o      (exp_par_s)
  );

  // Next-state and output computation for the frame FSM
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    done_d     = 1'b0;
    valid_d    = 1'b0;
    par_err_d  = par_err_q;
    stp_err_d  = stp_err_q;
    brk_d      = brk_q;
    zero_d     = zero_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    two_stop_d = two_stop_q;

    if (frame_start && prescale_ok_s) begin
      // A new start bit always wins, aborting any frame in progress
      state_d    = DATA;
      bit_cnt_d  = '0;
      data_d     = '0;
      par_err_d  = 1'b0;
      stp_err_d  = 1'b0;
      brk_d      = 1'b0;
      zero_d     = 1'b1;
      par_en_d   = par_en;
      par_type_d = par_type;
      two_stop_d = two_stop;
    end else if (strobe_s) begin
      case (state_q)
        DATA: begin
          data_d = {sampled_bit, data_q[DATA_WIDTH-1:1]};
          zero_d = zero_q & ~sampled_bit;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        PARITY: begin
          par_err_d = (sampled_bit != exp_par_s);
          zero_d    = zero_q & ~sampled_bit;
          state_d   = STOP1;
        end
        STOP1: begin
          stp_err_d = stp_err_q | ~sampled_bit;
          brk_d     = zero_q & ~sampled_bit;
          if (two_stop_q == STOP_TWO) begin
            state_d = STOP2;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            valid_d = ~(par_err_q | stp_err_q | ~sampled_bit);
          end
        end
        STOP2: begin
          stp_err_d = stp_err_q | ~sampled_bit;
          state_d   = IDLE;
          done_d    = 1'b1;
          valid_d   = ~(par_err_q | stp_err_q | ~sampled_bit);
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    busy_d = (state_d != IDLE);
  end

  // Frame state and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      brk_q      <= 1'b0;
      zero_q     <= 1'b0;
      par_en_q   <= 1'b0;
      par_type_q <= PAR_EVEN;
      two_stop_q <= STOP_ONE;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
      brk_q      <= brk_d;
      zero_q     <= zero_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      two_stop_q <= two_stop_d;
    end
  end

  assign busy       = busy_q;
  assign data_out   = data_q;
  assign frame_done = done_q;
  assign data_valid = valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
  assign brk_det    = brk_q;

endmodule : uart_rx_frame_check

// File: doc/uart_rx_frame_check.md
# uart_rx_frame_check

Parametrised UART receive frame checker that replaces the single stop-bit checker in the UART_RX path. It tracks one frame from the start-bit hand-off through DATA_WIDTH data bits, an optional parity bit and one or two stop bits, all sampled on the shared edge counter. It assembles the data word (LSB first) and reports parity error, stop error and break per frame. It sits between the data sampler / edge counter and the RX output register.

## Interface
- PRESCALE_WIDTH, 6, width of Prescale and edge_cnt
- DATA_WIDTH, 8, data bits per frame (5..9 supported)
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- Prescale  input  PRESCALE_WIDTH  clocks per bit; values 0 and 1 unsupported
- edge_cnt  input  PRESCALE_WIDTH  edge counter, 0..Prescale-1, wraps per bit
- sampled_bit  input  1  majority-sampled line value, stable when edge_cnt == Prescale-1
- frame_start  input  1  one-cycle pulse on the last edge of an accepted start bit
- par_en  input  1  parity bit present
- par_type  input  1  0 = even, 1 = odd
- two_stop  input  1  0 = one stop bit, 1 = two stop bits
- busy  output  1  frame in progress
- data_out  output  DATA_WIDTH  received word, held until next frame_start
- frame_done  output  1  one-cycle pulse at end of frame
- data_valid  output  1  one-cycle pulse with frame_done when par_err = stp_err = 0
- par_err  output  1  parity mismatch, held until next frame_start
- stp_err  output  1  a stop bit sampled 0, held until next frame_start
- brk_det  output  1  break detected, held until next frame_start

## Operation
- Bit strobe: strobe = busy && (edge_cnt == Prescale-1), compared in PRESCALE_WIDTH bits.
- States: IDLE, DATA, PARITY, STOP1, STOP2.
- IDLE: on frame_start with Prescale >= 2, go to DATA, clear bit counter, data_out and all flags, and latch par_en, par_type and two_stop. frame_start with Prescale < 2 is ignored.
- DATA: each strobe shifts sampled_bit into data_out MSB-side (LSB first on line). After bit DATA_WIDTH-1, go to PARITY if par_en, else STOP1.
- PARITY: on strobe, expected = ^data (even) or ~^data (odd); par_err = (sampled_bit != expected). Go to STOP1.
- STOP1: on strobe, stp_err |= ~sampled_bit. brk_det = 1 if all data bits, the parity bit (if enabled) and this stop bit are 0. Go to STOP2 if two_stop, else end the frame.
- STOP2: on strobe, stp_err |= ~sampled_bit, then end the frame.
- End of frame: frame_done = 1 and data_valid = ~(par_err | stp_err) for one cycle, using the final flag values. Return to IDLE.
- frame_start while busy: abort the current frame without frame_done, clear flags and data, and restart in DATA.
- Config inputs are ignored except at frame_start.

## Timing
- Reset values: busy 0, data_out 0, frame_done 0, data_valid 0, par_err 0, stp_err 0, brk_det 0, state IDLE.
- Reset mid-frame returns to these values immediately (asynchronous).
- All outputs are registered. Effects of a strobe cycle become visible after the rising edge that ends that cycle.
- busy goes to 1 on the edge that samples frame_start. It returns to 0 on the same edge that sets frame_done.
- Frame length after frame_start: (DATA_WIDTH + par_en + 1 + two_stop) × Prescale clocks to frame_done.
- Back-to-back frames: frame_start is legal in the cycle frame_done is high; flags clear on the next edge.

## Structure
- Package uart_rx_pkg holds:
  - state enum (IDLE, DATA, PARITY, STOP1, STOP2)
  - PAR_EVEN / PAR_ODD constants
  - STOP_ONE / STOP_TWO constants
  - the minimum legal Prescale constant (2)
- One sub-module, uart_parity_calc (DATA_WIDTH data + par_type → expected parity bit), shared with the TX side.
- Bit counter is $clog2(DATA_WIDTH+1) bits wide.

## Test plan
All scenarios use Prescale = 8 and DATA_WIDTH = 8.
- Clean frame: 8'hA5, par_en = 0, one stop → data_out = 8'hA5, frame_done and data_valid pulse 72 clocks after frame_start, all flags 0.
- Even parity: 8'h07 with parity bit 0 → par_err = 1, data_valid stays 0. Same frame with parity bit 1 → par_err = 0, data_valid = 1.
- Two stop bits: second stop sampled 0 → stp_err = 1, frame_done 80 clocks after frame_start. First stop 1 and second stop 1 → no error.
- Break: data 8'h00, odd parity bit 0, stop 0 → brk_det = 1, stp_err = 1, data_valid = 0.
- Abort: frame_start reasserted during data bit 4 → no frame_done for the first frame; the second frame 8'h3C completes normally.
- Reset mid-frame: reset_n low during PARITY → all outputs 0 immediately; a new frame after reset completes cleanly. Prescale = 1 with frame_start → busy stays 0.
